branch_predictor_btb: RTL
=========================

Name: branch_predictor_btb

Overview:
Parametrised branch predictor for the pipelined RV32 core's IF stage: a direct-mapped branch target buffer with per-entry saturating direction counters.
- Predicts next fetch PC for the current PC.
- Takes resolution information from MEM stage.
- Raises mispredict/redirect so pipeline control can flush IF/ID and ID/EX.
- Replaces the fixed "always PC+4, resolve in MEM" fetch policy; adds performance counters.

Parameters:
XLEN, 32, datapath/PC width
ENTRIES, 16, BTB entries; power of two, >= 2; IDX_W = log2(ENTRIES)
CNT_W, 2, direction counter width (>= 1)
PERF_W, 16, width of each saturating performance counter

Ports:
CLOCK  in  1  clock, all state updates on rising edge
RST_n  in  1  reset, synchronous, active-low
bp_clear  in  1  synchronous invalidate of all entries (e.g. fence.i)
pc_if  in  XLEN  current fetch PC
pred_taken  out  1  prediction for pc_if: redirect fetch
pred_target  out  XLEN  predicted target (valid when pred_taken)
pred_next_pc  out  XLEN  pred_taken ? pred_target : pc_if+4
upd_valid  in  1  MEM-stage instruction valid (not bubble/flushed)
upd_pc  in  XLEN  PC of MEM-stage instruction
upd_is_branch  in  1  conditional branch (B-type)
upd_is_jump  in  1  jal or jalr
upd_taken  in  1  resolved direction (1 for jumps)
upd_target  in  XLEN  resolved target
upd_pred_taken  in  1  prediction made at fetch, carried down pipeline
upd_pred_target  in  XLEN  predicted target carried down pipeline
mispredict  out  1  flush request, combinational from upd_*
redirect_pc  out  XLEN  correct next PC when mispredict
perf_ctrl  out  PERF_W  count of resolved control instructions
perf_mispred  out  PERF_W  count of mispredicts

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; pc[1:0] ignored.
- Entry: valid, tag, target[XLEN], is_jump, cnt[CNT_W].
- Lookup (combinational on stored state):
  - hit = valid & tag match.
  - pred_taken = hit & (is_jump | cnt MSB).
  - pc_if+4 wraps modulo 2^XLEN.
- Reset (RST_n=0 at edge):
  - all valid=0, all cnt=WEAK_NT (MSB 0, rest 1), perf counters 0.
  - Any update presented in that cycle is discarded.
  - Outputs after reset: pred_taken=0, pred_next_pc=pc_if+4.
  - mispredict/redirect_pc remain purely combinational from upd_*.
- Priority at an edge: RST_n low > bp_clear > update. bp_clear zeroes valid bits only; perf counters keep their values.
- Update, when upd_valid & (upd_is_branch | upd_is_jump):
  - Hit at upd index:
    - branch: cnt saturating +1 if taken, -1 if not.
    - jump: cnt forced to all-ones.
    - target overwritten with upd_target when taken.
  - Miss:
    - allocate only if upd_taken; overwrite victim.
    - valid=1, tag, target, is_jump.
    - cnt = WEAK_T (MSB 1, rest 0) for branch, all-ones for jump.
  - Not-taken miss: no write.
- Non-control instruction, when upd_valid & !upd_is_branch & !upd_is_jump & upd_pred_taken (alias hit):
  - mispredict=1, redirect_pc=upd_pc+4.
  - Matching entry invalidated at the edge.
- mispredict = upd_valid & ctrl & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target)), OR the non-control alias case above.
- redirect_pc = upd_taken ? upd_target : upd_pc+4. Driven every cycle; meaningful only when mispredict=1.
- upd_valid=0: no state change, mispredict=0.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents; the new entry is visible from the next cycle.
- perf_ctrl increments per valid control update. perf_mispred increments when mispredict=1. Both saturate at all-ones; no wrap.
- No internal pipelining. Prediction latency 0 cycles. Update-to-visibility 1 cycle.

Decomposition:
- Package bp_pkg holds:
  - counter encoding constants STRONG_NT/WEAK_NT/WEAK_T/STRONG_T (for CNT_W=2) and generic MSB rule.
  - typedef struct bp_entry_t {valid, tag, target, is_jump, cnt}, parameterised via localparams.
  - function clog2-based IDX_W helper.
- One sub-module: bp_sat_counter (CNT_W, inc/dec/set inputs, saturating), instantiated in the update path.
- Tables are register arrays; no RAM macro.

Test Plan (ENTRIES=16, CNT_W=2, PERF_W=4):
1. Reset then pc_if=0x100 -> pred_taken=0, pred_next_pc=0x104, perf_ctrl=0, perf_mispred=0; pc_if=0xFFFFFFFC -> pred_next_pc=0x0.
2. Update branch pc 0x100, taken, target 0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80; next cycle pc_if=0x100 -> pred_taken=1, pred_next_pc=0x80; pc_if=0x140 (same index, other tag) -> pred_taken=0.
3. Hysteresis: after scenario 2, one not-taken update -> pred_taken=0; taken, taken -> pred_taken=1 (STRONG_T); one not-taken -> still pred_taken=1.
4. Jump pc 0x200, target 0x300, then jalr same pc target 0x340 with upd_pred_target=0x300 -> mispredict=1, redirect_pc=0x340, next lookup target 0x340.
5. Non-control at 0x100 with upd_pred_taken=1 -> mispredict=1, redirect_pc=0x104; next cycle pc_if=0x100 -> miss. Same-cycle update+lookup at 0x100 -> old prediction that cycle.
6. 20 consecutive mispredicting updates -> perf_mispred=15 (saturated); bp_clear -> all lookups miss, perf unchanged; RST_n low with upd_valid=1 -> no allocation, counters 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants, types and helpers for the BTB branch predictor.
package bp_pkg;

  // Default geometry, used for the reference entry layout below.
  localparam int BP_XLEN    = 32;
  localparam int BP_ENTRIES = 16;
  localparam int BP_CNT_W   = 2;

  // Index width for a power-of-two entry count.
  function automatic int bp_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  localparam int BP_IDX_W = bp_idx_w(BP_ENTRIES);
  localparam int BP_TAG_W = BP_XLEN - BP_IDX_W - 2;

  // Two-bit direction counter encodings.
  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  // Generic encodings for any width: the MSB is the taken bit.
  // Weak not-taken is MSB 0 with the rest 1; weak taken is MSB 1 with the rest 0.
  function automatic int cnt_weak_nt(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int cnt_weak_t(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int cnt_strong_t(input int w);
    return (1 << w) - 1;
  endfunction

  // Reference entry layout at the default geometry.
  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    logic                is_jump;
    logic [BP_CNT_W-1:0] cnt;
  } bp_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down counter step with an override load.
module bp_sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             inc,
  input  logic             dec,
  input  logic             set,
  input  logic [CNT_W-1:0] set_val,
  output logic [CNT_W-1:0] cnt_out
);

  // Load wins over counting; counting stops at both ends.
  always_comb begin
    cnt_out = cnt_in;
    if (set)
      cnt_out = set_val;
    else if (inc && (cnt_in != {CNT_W{1'b1}}))
      cnt_out = cnt_in + 1'b1;
    else if (dec && (cnt_in != {CNT_W{1'b0}}))
      cnt_out = cnt_in - 1'b1;
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry direction counters for the IF stage.
// Lookup is combinational on stored state; MEM-stage resolution updates
// the table at the clock edge and raises a combinational flush request.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 16
) (
  input  logic              CLOCK,
  input  logic              RST_n,
  input  logic              bp_clear,
  input  logic [XLEN-1:0]   pc_if,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  output logic [XLEN-1:0]   pred_next_pc,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_is_branch,
  input  logic              upd_is_jump,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [XLEN-1:0]   upd_pred_target,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [PERF_W-1:0] perf_ctrl,
  output logic [PERF_W-1:0] perf_mispred
);

  localparam int IDX_W = bp_idx_w(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [CNT_W-1:0] C_WEAK_NT  = CNT_W'(cnt_weak_nt(CNT_W));
  localparam logic [CNT_W-1:0] C_WEAK_T   = CNT_W'(cnt_weak_t(CNT_W));
  localparam logic [CNT_W-1:0] C_STRONG_T = CNT_W'(cnt_strong_t(CNT_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic             is_jump;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  entry_t tbl [ENTRIES];

  logic [PERF_W-1:0] perf_ctrl_q;
  logic [PERF_W-1:0] perf_mispred_q;

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  entry_t           f_ent;
  logic             f_hit;

  assign f_idx = pc_if[IDX_W+1:2];
  assign f_tag = pc_if[XLEN-1:IDX_W+2];
  assign f_ent = tbl[f_idx];
  assign f_hit = f_ent.valid && (f_ent.tag == f_tag);

  assign pred_taken   = f_hit && (f_ent.is_jump || f_ent.cnt[CNT_W-1]);
  assign pred_target  = f_ent.target;
  assign pred_next_pc = pred_taken ? f_ent.target : pc_if + XLEN'(4);

  // ---------------- resolution ----------------
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  entry_t           u_ent;
  logic             u_hit;
  logic             u_ctrl;
  logic             u_alias;
  logic             u_write;
  logic [CNT_W-1:0] u_cnt_next;

  assign u_idx   = upd_pc[IDX_W+1:2];
  assign u_tag   = upd_pc[XLEN-1:IDX_W+2];
  assign u_ent   = tbl[u_idx];
  assign u_hit   = u_ent.valid && (u_ent.tag == u_tag);
  assign u_ctrl  = upd_valid && (upd_is_branch || upd_is_jump);
  // A non-control instruction that was predicted taken hit an aliasing entry.
  assign u_alias = upd_valid && !upd_is_branch && !upd_is_jump && upd_pred_taken;
  // Not-taken misses leave the table alone.
  assign u_write = u_ctrl && (u_hit || upd_taken);

  assign mispredict = (u_ctrl && ((upd_taken != upd_pred_taken) ||
                                  (upd_taken && (upd_target != upd_pred_target))))
                      || u_alias;
  assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

  // Jumps and fresh allocations load a fixed value; branch hits count.
  bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .cnt_in  (u_ent.cnt),
    .inc     (upd_taken),
    .dec     (!upd_taken),
    .set     (upd_is_jump || !u_hit),
    .set_val (upd_is_jump ? C_STRONG_T : C_WEAK_T),
    .cnt_out (u_cnt_next)
  );

  // Table state: reset, then bulk invalidate, then the single MEM update.
  always_ff @(posedge CLOCK) begin
    if (!RST_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i].valid <= 1'b0;
        tbl[i].cnt   <= C_WEAK_NT;
      end
    end else if (bp_clear) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl[i].valid <= 1'b0;
    end else if (u_write) begin
      tbl[u_idx].cnt <= u_cnt_next;
      if (upd_taken)
        tbl[u_idx].target <= upd_target;
      if (!u_hit) begin
        tbl[u_idx].valid   <= 1'b1;
        tbl[u_idx].tag     <= u_tag;
        tbl[u_idx].is_jump <= upd_is_jump;
      end
    end else if (u_alias && u_hit) begin
      tbl[u_idx].valid <= 1'b0;
    end
  end

  // Saturating performance counters; a bulk invalidate does not touch them.
  always_ff @(posedge CLOCK) begin
    if (!RST_n) begin
      perf_ctrl_q    <= '0;
      perf_mispred_q <= '0;
    end else if (!bp_clear) begin
      if (u_ctrl && (perf_ctrl_q != {PERF_W{1'b1}}))
        perf_ctrl_q <= perf_ctrl_q + 1'b1;
      if (mispredict && (perf_mispred_q != {PERF_W{1'b1}}))
        perf_mispred_q <= perf_mispred_q + 1'b1;
    end
  end

  assign perf_ctrl    = perf_ctrl_q;
  assign perf_mispred = perf_mispred_q;

endmodule
